// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel tick, raster addresses,
// delayed sync/active outputs and line/frame strobes.
module vga_timing_gen #(
  parameter int AW         = 10,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_DELAY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_en,
  output logic [AW-1:0] haddress,
  output logic [AW-1:0] vaddress,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW1     = AW + 1;

  if (H_TOTAL > 2**AW || V_TOTAL > 2**AW ||
      CLK_DIV < 1 || PIPE_DELAY < 1) begin : g_param_err
    $error("vga_timing_gen: illegal parameters");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] H_LAST   = AW'(H_TOTAL - 1);
  localparam logic [AW-1:0] V_LAST   = AW'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so an end bound equal
  // to 2^AW does not wrap to zero.
  localparam logic [AW:0] H_ACT  = AW1'(H_ACTIVE);
  localparam logic [AW:0] HS_BEG = AW1'(H_ACTIVE + H_FP);
  localparam logic [AW:0] HS_END = AW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [AW:0] V_ACT  = AW1'(V_ACTIVE);
  localparam logic [AW:0] VS_BEG = AW1'(V_ACTIVE + V_FP);
  localparam logic [AW:0] VS_END = AW1'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  logic [DW-1:0] div;
  logic [AW-1:0] h;
  logic [AW-1:0] v;
  logic          tick;
  logic [AW:0]   hx;
  logic [AW:0]   vx;
  sync_t         raw;
  sync_t         pipe [PIPE_DELAY];
  sync_t         last;

  assign tick = en && (div == DIV_LAST);
  assign hx   = {1'b0, h};
  assign vx   = {1'b0, v};

  // Pixel-tick divider; holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  // Raster counters; vertical steps when horizontal wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Raw sync/active decode of the current position.
  always_comb begin
    raw     = '0;
    raw.hs  = (hx >= HS_BEG) && (hx < HS_END);
    raw.vs  = (vx >= VS_BEG) && (vx < VS_END);
    raw.act = (hx < H_ACT) && (vx < V_ACT);
  end

  // Delay line aligning sync/active with downstream lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe[i] <= '0;
      end
    end else if (tick) begin
      pipe[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Output mapping with sync polarity applied.
  always_comb begin
    last        = pipe[PIPE_DELAY-1];
    pix_en      = tick && rst_n;
    haddress    = h;
    vaddress    = v;
    hsync       = last.hs ? HS_POL : ~HS_POL;
    vsync       = last.vs ? VS_POL : ~VS_POL;
    active      = last.act;
    line_start  = pix_en && (h == '0);
    frame_start = line_start && (v == '0);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked
// against an absolute tick-count raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int runs  = 0;
  int fails = 0;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int hp, vp, cd, pd;
  } cfg_t;

  cfg_t c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 1};
  cfg_t c1 = '{16, 3, 5, 4, 6, 2, 2, 3, 0, 1, 2, 2};
  cfg_t c2 = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 4, 3};

  logic       rst0_n, en0, p0, ls0, fs0, hs0, vs0, a0;
  logic [9:0] h0, v0;
  logic       rst1_n, en1, p1, ls1, fs1, hs1, vs1, a1;
  logic [9:0] h1, v1;
  logic       rst2_n, en2, p2, ls2, fs2, hs2, vs2, a2;
  logic [9:0] h2, v2;

  logic [25:0] o0, o1, o2;
  assign o0 = {p0, ls0, fs0, h0, v0, hs0, vs0, a0};
  assign o1 = {p1, ls1, fs1, h1, v1, hs1, vs1, a1};
  assign o2 = {p2, ls2, fs2, h2, v2, hs2, vs2, a2};

  int cnt0, cnt1, cnt2;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst0_n), .en(en0), .pix_en(p0),
    .haddress(h0), .vaddress(v0), .hsync(hs0), .vsync(vs0),
    .active(a0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(2), .PIPE_DELAY(2)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .pix_en(p1),
    .haddress(h1), .vaddress(v1), .hsync(hs1), .vsync(vs1),
    .active(a1), .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .HS_POL(1'b1), .CLK_DIV(4), .PIPE_DELAY(3)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .pix_en(p2),
    .haddress(h2), .vaddress(v2), .hsync(hs2), .vsync(vs2),
    .active(a2), .line_start(ls2), .frame_start(fs2)
  );

  // Enabled-clock counters since reset, one per instance.
  always @(posedge clk or negedge rst0_n)
    if (!rst0_n) cnt0 <= 0;
    else if (en0) cnt0 <= cnt0 + 1;

  always @(posedge clk or negedge rst1_n)
    if (!rst1_n) cnt1 <= 0;
    else if (en1) cnt1 <= cnt1 + 1;

  always @(posedge clk or negedge rst2_n)
    if (!rst2_n) cnt2 <= 0;
    else if (en2) cnt2 <= cnt2 + 1;

  // Expected outputs from the number of completed pixel ticks:
  // position is tick index mod line/frame length, and delayed
  // outputs show the position pd ticks back.
  function automatic logic [25:0] model(cfg_t c, int cnt,
                                        logic en, logic rn);
    int ht, vt, n, h, v, k, kh, kv;
    logic pix, hs, vs, act;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    n   = cnt / c.cd;
    h   = n % ht;
    v   = (n / ht) % vt;
    pix = rn && en && ((cnt % c.cd) == c.cd - 1);
    hs  = 1'b0;
    vs  = 1'b0;
    act = 1'b0;
    if (n >= c.pd) begin
      k   = n - c.pd;
      kh  = k % ht;
      kv  = (k / ht) % vt;
      hs  = (kh >= c.ha + c.hf) && (kh < c.ha + c.hf + c.hs);
      vs  = (kv >= c.va + c.vf) && (kv < c.va + c.vf + c.vs);
      act = (kh < c.ha) && (kv < c.va);
    end
    return {pix, pix && h == 0, pix && h == 0 && v == 0,
            10'(h), 10'(v),
            hs ? 1'(c.hp) : ~1'(c.hp),
            vs ? 1'(c.vp) : ~1'(c.vp),
            act};
  endfunction

  task automatic test_reset();
    logic [25:0] e;
    rst0_n = 0; rst1_n = 0; rst2_n = 0;
    en0 = 1; en1 = 1; en2 = 1;
    repeat (3) @(negedge clk);
    e = model(c0, cnt0, en0, rst0_n);
    runs++;
    if (o0 !== e) begin
      fails++;
      $display("FAIL reset0: got %h want %h", o0, e);
    end
    e = model(c1, cnt1, en1, rst1_n);
    runs++;
    if (o1 !== e) begin
      fails++;
      $display("FAIL reset1: got %h want %h", o1, e);
    end
    e = model(c2, cnt2, en2, rst2_n);
    runs++;
    if (o2 !== e) begin
      fails++;
      $display("FAIL reset2: got %h want %h", o2, e);
    end
    runs++;
    if ({hs0, vs0, a0, p0} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_lvl0: got %b want 1100",
               {hs0, vs0, a0, p0});
    end
    runs++;
    if ({hs2, vs2, a2} !== 3'b010) begin
      fails++;
      $display("FAIL reset_lvl2: got %b want 010",
               {hs2, vs2, a2});
    end
    rst0_n = 1; rst1_n = 1; rst2_n = 1;
    #1;
    runs++;
    if ({p0, ls0, fs0} !== 3'b111) begin
      fails++;
      $display("FAIL startup0: got %b want 111",
               {p0, ls0, fs0});
    end
    e = model(c0, cnt0, en0, rst0_n);
    runs++;
    if (o0 !== e) begin
      fails++;
      $display("FAIL startup0_all: got %h want %h", o0, e);
    end
  endtask

  task automatic test_horizontal();
    logic [25:0] e;
    int hs_lo = 0;
    int act_hi = 0;
    int bad = 0;
    repeat (2400) begin
      @(negedge clk);
      e = model(c0, cnt0, en0, rst0_n);
      runs++;
      if (o0 !== e) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL horiz: got %h want %h", o0, e);
      end
      if (p0 && v0 == 10'd1) begin
        if (!hs0) hs_lo++;
        if (a0) act_hi++;
      end
      en0 = ($urandom_range(7) != 0);
    end
    en0 = 1;
    runs++;
    if (hs_lo != 96) begin
      fails++;
      $display("FAIL hsync_width: got %0d want 96", hs_lo);
    end
    runs++;
    if (act_hi != 640) begin
      fails++;
      $display("FAIL active_width: got %0d want 640", act_hi);
    end
  endtask

  task automatic test_enable();
    logic [25:0] e;
    int n = 0;
    int bad = 0;
    en0 = 1;
    do begin
      @(negedge clk);
      n++;
    end while (h0 != 10'd700 && n < 2000);
    runs++;
    if (h0 !== 10'd700) begin
      fails++;
      $display("FAIL en_wait: got %0d want 700", h0);
    end
    en0 = 0;
    repeat (37) begin
      @(negedge clk);
      e = model(c0, cnt0, en0, rst0_n);
      runs++;
      if (o0 !== e || h0 !== 10'd700) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL freeze: got %h want %h", o0, e);
      end
    end
    en0 = 1;
    @(negedge clk);
    runs++;
    if (h0 !== 10'd701) begin
      fails++;
      $display("FAIL resume: got %0d want 701", h0);
    end
    e = model(c0, cnt0, en0, rst0_n);
    runs++;
    if (o0 !== e) begin
      fails++;
      $display("FAIL resume_all: got %h want %h", o0, e);
    end
  endtask

  task automatic test_frame();
    logic [25:0] e;
    int n = 0;
    int bad = 0;
    repeat (2500) begin
      @(negedge clk);
      e = model(c1, cnt1, en1, rst1_n);
      runs++;
      if (o1 !== e) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL frame: got %h want %h", o1, e);
      end
      en1 = ($urandom_range(3) != 0);
    end
    en1 = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!fs1 && n < 2000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs1 && n < 2000);
    runs++;
    if (n != 728) begin
      fails++;
      $display("FAIL frame_period: got %0d want 728", n);
    end
  endtask

  task automatic test_divider();
    logic [25:0] e;
    int n = 0;
    int hs_hi = 0;
    int bad = 0;
    repeat (3000) begin
      @(negedge clk);
      e = model(c2, cnt2, en2, rst2_n);
      runs++;
      if (o2 !== e) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL divider: got %h want %h", o2, e);
      end
      en2 = ($urandom_range(5) != 0);
    end
    en2 = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!ls2 && n < 4000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (p2 && hs2) hs_hi++;
    end while (!ls2 && n < 4000);
    runs++;
    if (n != 3200) begin
      fails++;
      $display("FAIL line_period: got %0d want 3200", n);
    end
    runs++;
    if (hs_hi != 96) begin
      fails++;
      $display("FAIL hsync_hi: got %0d want 96", hs_hi);
    end
  endtask

  task automatic test_mid_reset();
    logic [25:0] e;
    int n = 0;
    int bad = 0;
    en1 = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!(v1 == 10'd4 && h1 == 10'd10) && n < 2000);
    #2;
    rst1_n = 0;
    #1;
    e = model(c1, cnt1, en1, rst1_n);
    runs++;
    if (o1 !== e) begin
      fails++;
      $display("FAIL async_rst: got %h want %h", o1, e);
    end
    runs++;
    if ({h1, v1, hs1, vs1, a1} !== {20'd0, 3'b100}) begin
      fails++;
      $display("FAIL async_lvl: got %h want %h",
               {h1, v1, hs1, vs1, a1}, {20'd0, 3'b100});
    end
    @(negedge clk);
    rst1_n = 1;
    repeat (200) begin
      @(negedge clk);
      e = model(c1, cnt1, en1, rst1_n);
      runs++;
      if (o1 !== e) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL restart: got %h want %h", o1, e);
      end
      en1 = ($urandom_range(4) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_enable();
    test_frame();
    test_divider();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
